// File: rtl/image_buffer_loader_if.sv
// Byte-stream handshake bundle between the host front end and the image loader:
// rx carries image bytes into the loader, tx returns the tagged result byte.
interface image_buffer_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/image_buffer_loader.sv
// Packs a host byte stream into the BNN image vector and returns the class result as a tagged byte.
// Optional feature macro: CHECKSUM_EN (trailing XOR byte validates each image).
module image_buffer_loader #(
    parameter int unsigned IMG_BITS   = 904,
    parameter logic [3:0]  RESULT_TAG = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    image_buffer_loader_if.slave bus,
    input  logic                 buffer_clear,
    output logic [IMG_BITS-1:0]  img_out,
    output logic                 img_buffer_full,
    input  logic [3:0]           result_in,
    input  logic                 result_ready,
    output logic [6:0]           fill_count,
    output logic                 overflow_err,
    output logic                 checksum_err
);
    localparam int unsigned NUM_BYTES = IMG_BITS / 8;
    localparam int unsigned IDX_W     = $clog2(IMG_BITS);
    localparam logic [6:0]  LAST_CNT  = 7'(NUM_BYTES - 1);
`ifdef CHECKSUM_EN
    localparam logic [6:0]  FULL_CNT  = 7'(NUM_BYTES);
`endif

    typedef enum logic [1:0] {
        FILL,
        WAIT_RESULT,
        SEND
    } state_e;

    state_e              state_q, state_d;
    logic [IMG_BITS-1:0] img_q, img_d;
    logic [6:0]          fill_count_q, fill_count_d;
    logic                full_q, full_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                overflow_err_q, overflow_err_d;
    logic                rx_ready_c;
    logic                rx_fire_c;
    logic [IDX_W-1:0]    byte_base_c;
`ifdef CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
    logic                checksum_err_q, checksum_err_d;
`endif

    assign rx_ready_c  = (state_q == FILL) && !buffer_clear;
    assign rx_fire_c   = bus.rx_valid && rx_ready_c;
    assign byte_base_c = IDX_W'({fill_count_q, 3'b000});

    // Next-state and registered-output logic; buffer_clear overrides every state.
    always_comb begin
        state_d        = state_q;
        img_d          = img_q;
        fill_count_d   = fill_count_q;
        full_d         = full_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        overflow_err_d = 1'b0;
`ifdef CHECKSUM_EN
        xor_d          = xor_q;
        checksum_err_d = 1'b0;
`endif
        if (buffer_clear) begin
            state_d      = FILL;
            fill_count_d = 7'd0;
            full_d       = 1'b0;
            tx_valid_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (rx_fire_c) begin
`ifdef CHECKSUM_EN
                        // A count of NUM_BYTES means the next byte is the checksum, not image data.
                        if (fill_count_q == FULL_CNT) begin
                            if (bus.rx_data == xor_q) begin
                                state_d = WAIT_RESULT;
                                full_d  = 1'b1;
                            end else begin
                                checksum_err_d = 1'b1;
                                fill_count_d   = 7'd0;
                            end
                        end else begin
                            img_d[byte_base_c +: 8] = bus.rx_data;
                            xor_d        = ((fill_count_q == 7'd0) ? 8'h00 : xor_q) ^ bus.rx_data;
                            fill_count_d = fill_count_q + 7'd1;
                        end
`else
                        img_d[byte_base_c +: 8] = bus.rx_data;
                        fill_count_d = fill_count_q + 7'd1;
                        if (fill_count_q == LAST_CNT) begin
                            state_d = WAIT_RESULT;
                            full_d  = 1'b1;
                        end
`endif
                    end
                end
                WAIT_RESULT: begin
                    overflow_err_d = bus.rx_valid;
                    if (result_ready) begin
                        tx_data_d  = {RESULT_TAG, result_in};
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end
                end
                SEND: begin
                    overflow_err_d = bus.rx_valid;
                    if (tx_valid_q && bus.tx_ready) begin
                        tx_valid_d   = 1'b0;
                        full_d       = 1'b0;
                        fill_count_d = 7'd0;
                        state_d      = FILL;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FILL;
            img_q          <= '0;
            fill_count_q   <= 7'd0;
            full_q         <= 1'b0;
            tx_data_q      <= 8'h00;
            tx_valid_q     <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            img_q          <= img_d;
            fill_count_q   <= fill_count_d;
            full_q         <= full_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            overflow_err_q <= overflow_err_d;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q          <= 8'h00;
            checksum_err_q <= 1'b0;
        end else begin
            xor_q          <= xor_d;
            checksum_err_q <= checksum_err_d;
        end
    end
    assign checksum_err = checksum_err_q;
`else
    assign checksum_err = 1'b0;
`endif

    assign bus.rx_ready    = rx_ready_c;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign img_out         = img_q;
    assign img_buffer_full = full_q;
    assign fill_count      = fill_count_q;
    assign overflow_err    = overflow_err_q;
endmodule

// File: tb/tb_image_buffer_loader.sv
// Self-checking bench for image_buffer_loader: directed table, corner sequences and
// randomized traffic against a byte-array reference model.
module tb_image_buffer_loader;
    localparam int unsigned IMG_BITS = 904;
    localparam int unsigned NB       = IMG_BITS / 8;

    logic                clk;
    logic                rst_n;
    logic                buffer_clear;
    logic [IMG_BITS-1:0] img_out;
    logic                img_buffer_full;
    logic [3:0]          result_in;
    logic                result_ready;
    logic [6:0]          fill_count;
    logic                overflow_err;
    logic                checksum_err;

    image_buffer_loader_if bus();

    image_buffer_loader #(.IMG_BITS(IMG_BITS), .RESULT_TAG(4'hA)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .buffer_clear   (buffer_clear),
        .img_out        (img_out),
        .img_buffer_full(img_buffer_full),
        .result_in      (result_in),
        .result_ready   (result_ready),
        .fill_count     (fill_count),
        .overflow_err   (overflow_err),
        .checksum_err   (checksum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 collecting, 1 awaiting result, 2 handing result back.
    int         m_phase;
    int         m_cnt;
    logic [7:0] m_img [NB];
    logic [7:0] m_txd;
    logic       m_txv;
    logic       m_ovf;
    logic       m_ck;

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       rr;
        logic [3:0] res;
        logic       tr;
        logic       exp_full;
        logic       exp_txv;
        logic [7:0] exp_txd;
        logic       exp_ovf;
        logic [6:0] exp_cnt;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [IMG_BITS-1:0] act, input logic [IMG_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_phase = 0;
        m_cnt   = 0;
        foreach (m_img[k]) m_img[k] = 8'h00;
        m_txd = 8'h00;
        m_txv = 1'b0;
        m_ovf = 1'b0;
        m_ck  = 1'b0;
    endtask

    function automatic logic m_ready();
        return (m_phase == 0) && !buffer_clear;
    endfunction

    function automatic logic [IMG_BITS-1:0] m_vec();
        logic [IMG_BITS-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = m_img[k];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic m_update();
        logic [7:0] x;
        m_ovf = 1'b0;
        m_ck  = 1'b0;
        if (buffer_clear) begin
            m_phase = 0;
            m_cnt   = 0;
            m_txv   = 1'b0;
        end else if (m_phase == 0) begin
            if (bus.rx_valid) begin
                if (m_cnt < NB) begin
                    m_img[m_cnt] = bus.rx_data;
                    m_cnt++;
`ifndef CHECKSUM_EN
                    if (m_cnt == NB) m_phase = 1;
`endif
                end else begin
                    x = 8'h00;
                    foreach (m_img[k]) x ^= m_img[k];
                    if (x == bus.rx_data) m_phase = 1;
                    else begin
                        m_cnt = 0;
                        m_ck  = 1'b1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_ovf = bus.rx_valid;
            if (result_ready) begin
                m_txd   = {4'hA, result_in};
                m_txv   = 1'b1;
                m_phase = 2;
            end
        end else begin
            m_ovf = bus.rx_valid;
            if (bus.tx_ready) begin
                m_phase = 0;
                m_cnt   = 0;
                m_txv   = 1'b0;
            end
        end
    endtask

    // One clock: check rx_ready before the edge, then every registered output after it.
    task automatic step();
        #1;
        chk("rx_ready", IMG_BITS'(bus.rx_ready), IMG_BITS'(m_ready()));
        m_update();
        @(posedge clk);
        #1;
        chk("img_out", img_out, m_vec());
        chk("fill_count", IMG_BITS'(fill_count), IMG_BITS'(m_cnt));
        chk("img_buffer_full", IMG_BITS'(img_buffer_full), IMG_BITS'(m_phase != 0));
        chk("tx_valid", IMG_BITS'(bus.tx_valid), IMG_BITS'(m_txv));
        chk("tx_data", IMG_BITS'(bus.tx_data), IMG_BITS'(m_txd));
        chk("overflow_err", IMG_BITS'(overflow_err), IMG_BITS'(m_ovf));
        chk("checksum_err", IMG_BITS'(checksum_err), IMG_BITS'(m_ck));
    endtask

    task automatic set_idle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        buffer_clear = 1'b0;
        result_ready = 1'b0;
        result_in    = 4'h0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        step();
        bus.rx_valid = 1'b0;
    endtask

    // Sends NB random bytes (plus a correct checksum when enabled); returns their XOR.
    task automatic send_image(output logic [7:0] x);
        logic [7:0] b;
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            b = 8'($urandom);
            x ^= b;
            send_byte(b);
        end
`ifdef CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic return_result(input logic [3:0] r);
        result_ready = 1'b1;
        result_in    = r;
        step();
        result_ready = 1'b0;
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [7:0] x;
        logic [7:0] b;

        tbl[0] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'd113};
        tbl[1] = '{1'b1, 8'hFF, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 7'd113};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 7'd113};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 7'd113};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 7'd113};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 7'd113};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 7'd113};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 7'd113};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hA7, 1'b0, 7'd0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b0, 7'd0};

        // Reset held for three cycles
        set_idle();
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_img_out", img_out, '0);
        chk("rst_full", IMG_BITS'(img_buffer_full), '0);
        chk("rst_fill_count", IMG_BITS'(fill_count), '0);
        chk("rst_tx_data", IMG_BITS'(bus.tx_data), '0);
        chk("rst_tx_valid", IMG_BITS'(bus.tx_valid), '0);
        chk("rst_overflow", IMG_BITS'(overflow_err), '0);
        chk("rst_checksum", IMG_BITS'(checksum_err), '0);
        rst_n = 1'b1;
        #1;
        chk("rx_ready_after_reset", IMG_BITS'(bus.rx_ready), IMG_BITS'(1'b1));

        // Fill with 0x00..0x70 back-to-back
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            x ^= 8'(i);
            send_byte(8'(i));
            if (i == NB - 2) chk("full_before_last", IMG_BITS'(img_buffer_full), '0);
        end
`ifdef CHECKSUM_EN
        chk("full_awaiting_checksum", IMG_BITS'(img_buffer_full), '0);
        chk("count_awaiting_checksum", IMG_BITS'(fill_count), IMG_BITS'(7'd113));
        send_byte(x);
`endif
        chk("full_after_last", IMG_BITS'(img_buffer_full), IMG_BITS'(1'b1));
        #1;
        chk("rx_ready_when_full", IMG_BITS'(bus.rx_ready), '0);
        chk("img_first_byte", IMG_BITS'(img_out[7:0]), IMG_BITS'(8'h00));
        chk("img_last_byte", IMG_BITS'(img_out[903:896]), IMG_BITS'(8'h70));

        // Result hand-back, overflow and tx backpressure from the vector table
        for (int i = 0; i < 10; i++) begin
            bus.rx_valid = tbl[i].rxv;
            bus.rx_data  = tbl[i].rxd;
            result_ready = tbl[i].rr;
            result_in    = tbl[i].res;
            bus.tx_ready = tbl[i].tr;
            step();
            chk($sformatf("tbl%0d_full", i), IMG_BITS'(img_buffer_full), IMG_BITS'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_tx_valid", i), IMG_BITS'(bus.tx_valid), IMG_BITS'(tbl[i].exp_txv));
            chk($sformatf("tbl%0d_tx_data", i), IMG_BITS'(bus.tx_data), IMG_BITS'(tbl[i].exp_txd));
            chk($sformatf("tbl%0d_overflow", i), IMG_BITS'(overflow_err), IMG_BITS'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_fill_count", i), IMG_BITS'(fill_count), IMG_BITS'(tbl[i].exp_cnt));
        end
        set_idle();
        chk("img_kept_after_overflow", IMG_BITS'(img_out[903:896]), IMG_BITS'(8'h70));

        // Clear after 50 bytes, with a byte offered in the clear cycle
        for (int i = 0; i < 50; i++) send_byte(8'($urandom));
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        buffer_clear = 1'b1;
        step();
        set_idle();
        chk("clear_fill_count", IMG_BITS'(fill_count), '0);
        chk("clear_no_overflow", IMG_BITS'(overflow_err), '0);
        x = 8'h00;
        for (int i = 0; i < NB - 1; i++) begin
            b = 8'($urandom);
            x ^= b;
            send_byte(b);
        end
        chk("clear_not_full_at_112", IMG_BITS'(img_buffer_full), '0);
        b = 8'($urandom);
        x ^= b;
        send_byte(b);
`ifdef CHECKSUM_EN
        send_byte(x);
`endif
        chk("clear_full_at_113", IMG_BITS'(img_buffer_full), IMG_BITS'(1'b1));
        return_result(4'hC);

`ifdef CHECKSUM_EN
        // Wrong checksum then a correct resend
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            b = 8'($urandom);
            x ^= b;
            send_byte(b);
        end
        send_byte(x ^ 8'h01);
        chk("ck_err_pulse", IMG_BITS'(checksum_err), IMG_BITS'(1'b1));
        chk("ck_err_not_full", IMG_BITS'(img_buffer_full), '0);
        chk("ck_err_count", IMG_BITS'(fill_count), '0);
        step();
        chk("ck_err_one_cycle", IMG_BITS'(checksum_err), '0);
        send_image(x);
        chk("ck_ok_full", IMG_BITS'(img_buffer_full), IMG_BITS'(1'b1));
        return_result(4'h2);
`endif

        // Asynchronous reset in the middle of SEND
        send_image(x);
        result_ready = 1'b1;
        result_in    = 4'h9;
        step();
        set_idle();
        chk("pre_reset_tx_valid", IMG_BITS'(bus.tx_valid), IMG_BITS'(1'b1));
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("midsend_tx_valid", IMG_BITS'(bus.tx_valid), '0);
        chk("midsend_full", IMG_BITS'(img_buffer_full), '0);
        chk("midsend_img", img_out, '0);
        chk("midsend_count", IMG_BITS'(fill_count), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.rx_valid = ($urandom % 4) != 0;
            bus.rx_data  = 8'($urandom);
            buffer_clear = ($urandom % 400) == 0;
            result_ready = ($urandom % 8) == 0;
            result_in    = 4'($urandom);
            bus.tx_ready = ($urandom % 3) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
